// File: rtl/event_stretcher_pkg.sv
// Shared definitions for the event stretcher.
//
// Holds the FSM state type and the default interval widths/lengths. The
// 15-bit interval matches the button debouncer, so both blocks use the same
// slow divided clock and produce human-scale timing from the same constants.

package event_stretcher_pkg;

    // Blink sequencer states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2
    } state_e;

    // Default interval counter width, shared with the debouncer.
    localparam int unsigned DefCntW      = 15;
    // Default LED high time and minimum low gap, in clk cycles.
    localparam int unsigned DefOnCycles  = 32768;
    localparam int unsigned DefOffCycles = 32768;
    // Default pending-queue counter width (depth 2^W-1).
    localparam int unsigned DefPendW     = 4;

    // Largest count representable by an unsigned counter of the given width.
    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/event_stretcher_sat_counter.sv
// sat_counter: up/down counter that saturates at both ends.
//
// Used as the pending-event queue of the event stretcher, but has no
// knowledge of it. Simultaneous inc and dec cancel. An inc at the top or a
// dec at zero is ignored; the caller decides what that means.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset (count -> 0)
//   inc    in   request +1
//   dec    in   request -1
//   count  out  current count (registered)
//   sat    out  count is at its maximum, 2^W-1

module sat_counter
    import event_stretcher_pkg::*;
#(
    parameter int unsigned W = DefPendW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] CountMax = W'(sat_max(W));

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != CountMax)) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = (count_q == CountMax);

endmodule

// File: rtl/event_stretcher.sv
// event_stretcher: turns short event pulses into clean, visible LED blinks.
//
// Every accepted event produces exactly ON_CYCLES of led_out high followed by
// exactly OFF_CYCLES of led_out low, so consecutive events remain visually
// separate. Events that arrive while a blink is running are queued in a
// saturating pending counter and served in order; when the queue is full an
// extra event is dropped and the sticky overflow flag is raised.
//
// Build option:
//   EVENT_EDGE_EN  when defined, only 0->1 transitions of event_in count as
//                  events (a held level gives one blink); adds one cycle of
//                  latency. When undefined, every high cycle is an event.
//
// Ports:
//   clk       in   system clock (slow divided clock)
//   reset     in   synchronous, active-high reset; aborts any blink
//   event_in  in   event request
//   led_out   out  stretched pulse to the LED (registered)
//   busy      out  high whenever a blink or its gap is in progress (registered)
//   pending   out  queued events, excluding the blink in progress
//   overflow  out  sticky: an event was dropped because the queue was full

module event_stretcher
    import event_stretcher_pkg::*;
#(
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned ON_CYCLES  = DefOnCycles,
    parameter int unsigned OFF_CYCLES = DefOffCycles,
    parameter int unsigned PEND_W     = DefPendW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              event_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    // Intervals are loaded as length-1 and counted down to zero, so a length
    // of 2^CNT_W still fits in CNT_W bits.
    localparam logic [CNT_W-1:0] OnLoad  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OffLoad = CNT_W'(OFF_CYCLES - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               led_q;
    logic               busy_q;
    logic               overflow_q;

    logic               ev;
    logic               at_zero;
    logic               pend_nz;
    logic               pend_sat;
    logic               can_start;
    logic               start;
    logic               pend_inc;
    logic               pend_dec;
    logic               drop;

    // ------------------------------------------------------------------
    // Event strobe
    // ------------------------------------------------------------------
`ifdef EVENT_EDGE_EN
    logic event_q;
    logic strobe_q;

    // The edge strobe is registered so the rest of the logic sees a clean
    // single-cycle pulse one cycle after the rising edge is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            event_q  <= event_in;
            strobe_q <= event_in & ~event_q;
        end
    end

    assign ev = strobe_q;
`else
    assign ev = event_in;
`endif

    // ------------------------------------------------------------------
    // Start / queue decisions
    // ------------------------------------------------------------------
    assign at_zero   = (cnt_q == '0);
    assign pend_nz   = (pending != '0);

    // A new blink may begin from IDLE, or on the last cycle of the OFF gap
    // so back-to-back blinks have no idle cycle between them.
    assign can_start = (state_q == StIdle) || ((state_q == StOff) && at_zero);
    assign start     = can_start && (ev || pend_nz);

    // Queued events are served first; a fresh event only bypasses the queue
    // when the queue is empty and a blink is starting right now.
    assign pend_dec  = start && pend_nz;
    assign pend_inc  = ev && !(start && !pend_nz);
    assign drop      = pend_inc && !pend_dec && pend_sat;

    sat_counter #(
        .W (PEND_W)
    ) u_pending (
        .clk   (clk),
        .reset (reset),
        .inc   (pend_inc),
        .dec   (pend_dec),
        .count (pending),
        .sat   (pend_sat)
    );

    // ------------------------------------------------------------------
    // Blink sequencer with interval counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StOn;
                        cnt_q   <= OnLoad;
                        led_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                StOn: begin
                    if (at_zero) begin
                        state_q <= StOff;
                        cnt_q   <= OffLoad;
                        led_q   <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end

                StOff: begin
                    if (at_zero) begin
                        if (start) begin
                            state_q <= StOn;
                            cnt_q   <= OnLoad;
                            led_q   <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_event_stretcher.sv
// Self-checking bench for event_stretcher with short intervals
// (ON=4, OFF=3, PEND_W=2, CNT_W=2 so ON_CYCLES equals 2^CNT_W).
//
// The reference model works on blink start times: a blink started at edge s
// shows led high for edges s..s+ON-1, busy for s..s+ON+OFF-1, and the next
// blink may start at s+ON+OFF at the earliest. Pending is a plain integer.

module tb_event_stretcher;

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned ON     = 4;
    localparam int unsigned OFF    = 3;
    localparam int unsigned PEND_W = 2;
    localparam int          PMAX   = 3;

    logic              clk;
    logic              reset;
    logic              event_in;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    int n_tests;
    int n_fail;

    // Reference model state.
    int m_edge;
    int m_start;
    bit m_started;
    int m_pend;
    bit m_ovf;
    bit m_in1;
    bit m_strb;

    event_stretcher #(
        .CNT_W      (CNT_W),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .PEND_W     (PEND_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .event_in (event_in),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_led();
        return m_started && ((m_edge - m_start) < int'(ON));
    endfunction

    function automatic bit exp_busy();
        return m_started && ((m_edge - m_start) < int'(ON + OFF));
    endfunction

    // Advance the model by one sampled edge.
    function automatic void model_edge(input bit ev, input bit rst);
        bit s;
        bit avail;
        m_edge++;
        if (rst) begin
            m_started = 1'b0;
            m_pend    = 0;
            m_ovf     = 1'b0;
            m_in1     = 1'b0;
            m_strb    = 1'b0;
        end else begin
`ifdef EVENT_EDGE_EN
            s      = m_strb;
            m_strb = ev && !m_in1;
            m_in1  = ev;
`else
            s = ev;
`endif
            avail = !m_started || ((m_edge - m_start) >= int'(ON + OFF));
            if (avail && (s || m_pend > 0)) begin
                m_started = 1'b1;
                m_start   = m_edge;
                // Queued event consumed; a simultaneous new one takes its slot.
                if (m_pend > 0 && !s) m_pend--;
            end else if (s) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else m_pend++;
            end
        end
    endfunction

    task automatic tick(input bit ev, input bit rst);
        event_in = ev;
        reset    = rst;
        @(posedge clk);
        model_edge(ev, rst);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        n_tests++;
        if (led_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_led got %b exp 0", led_out);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b exp 0", busy);
        end
        n_tests++;
        if (pending !== '0) begin
            n_fail++; $display("FAIL reset_pending got %0d exp 0", pending);
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow);
        end
    endtask

    task automatic test_single();
        int highs;
        int busys;
        highs = 0;
        busys = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(i == 0, 1'b0);
            if (led_out === 1'b1) highs++;
            if (busy === 1'b1) busys++;
            n_tests++;
            if (led_out !== exp_led()) begin
                n_fail++; $display("FAIL single_led cyc %0d got %b exp %b", i, led_out, exp_led());
            end
            n_tests++;
            if (busy !== exp_busy()) begin
                n_fail++; $display("FAIL single_busy cyc %0d got %b exp %b", i, busy, exp_busy());
            end
            n_tests++;
            if (int'(pending) !== m_pend) begin
                n_fail++; $display("FAIL single_pending cyc %0d got %0d exp %0d", i, pending, m_pend);
            end
        end
`ifndef EVENT_EDGE_EN
        n_tests++;
        if (highs != int'(ON)) begin
            n_fail++; $display("FAIL single_high_len got %0d exp %0d", highs, ON);
        end
        n_tests++;
        if (busys != int'(ON + OFF)) begin
            n_fail++; $display("FAIL single_busy_len got %0d exp %0d", busys, ON + OFF);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int  rises;
        int  maxp;
        logic prev;
        rises = 0;
        maxp  = 0;
        prev  = 1'b0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 26; i++) begin
            tick(i < 3, 1'b0);
            if (led_out === 1'b1 && prev === 1'b0) rises++;
            prev = led_out;
            if (int'(pending) > maxp) maxp = int'(pending);
            n_tests++;
            if ({led_out, busy, pending, overflow} !== {exp_led(), exp_busy(), PEND_W'(m_pend), m_ovf}) begin
                n_fail++;
                $display("FAIL b2b cyc %0d got led%b busy%b pend%0d ovf%b exp led%b busy%b pend%0d ovf%b",
                         i, led_out, busy, pending, overflow, exp_led(), exp_busy(), m_pend, m_ovf);
            end
        end
`ifndef EVENT_EDGE_EN
        n_tests++;
        if (rises != 3) begin
            n_fail++; $display("FAIL b2b_blinks got %0d exp 3", rises);
        end
        n_tests++;
        if (maxp != 2) begin
            n_fail++; $display("FAIL b2b_max_pending got %0d exp 2", maxp);
        end
`endif
    endtask

    task automatic test_overflow();
        tick(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick(i < 10, 1'b0);
            n_tests++;
            if ({led_out, busy, pending, overflow} !== {exp_led(), exp_busy(), PEND_W'(m_pend), m_ovf}) begin
                n_fail++;
                $display("FAIL ovf cyc %0d got led%b busy%b pend%0d ovf%b exp led%b busy%b pend%0d ovf%b",
                         i, led_out, busy, pending, overflow, exp_led(), exp_busy(), m_pend, m_ovf);
            end
        end
`ifndef EVENT_EDGE_EN
        n_tests++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ovf_sticky got ovf%b busy%b exp ovf1 busy0", overflow, busy);
        end
`endif
        tick(1'b0, 1'b1);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_cleared got %b exp 0", overflow);
        end
    endtask

    task automatic test_last_off();
        int lows;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        lows = 0;
        for (int i = 0; i < int'(ON + OFF) - 1; i++) begin
            tick(1'b0, 1'b0);
            if (led_out === 1'b0) lows++;
            n_tests++;
            if (busy !== exp_busy() || led_out !== exp_led()) begin
                n_fail++;
                $display("FAIL lastoff cyc %0d got led%b busy%b exp led%b busy%b",
                         i, led_out, busy, exp_led(), exp_busy());
            end
        end
        tick(1'b1, 1'b0);
`ifndef EVENT_EDGE_EN
        n_tests++;
        if (lows != int'(OFF)) begin
            n_fail++; $display("FAIL lastoff_gap got %0d exp %0d", lows, OFF);
        end
        n_tests++;
        if (led_out !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL lastoff_restart got led%b busy%b exp led1 busy1", led_out, busy);
        end
`endif
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0);
            n_tests++;
            if (led_out !== exp_led() || busy !== exp_busy()) begin
                n_fail++;
                $display("FAIL lastoff_tail cyc %0d got led%b busy%b exp led%b busy%b",
                         i, led_out, busy, exp_led(), exp_busy());
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
`ifndef EVENT_EDGE_EN
        n_tests++;
        if (pending !== PEND_W'(2) || led_out !== 1'b1) begin
            n_fail++; $display("FAIL midrst_setup got pend%0d led%b exp pend2 led1", pending, led_out);
        end
`endif
        tick(1'b0, 1'b1);
        n_tests++;
        if ({led_out, busy, pending} !== {1'b0, 1'b0, PEND_W'(0)}) begin
            n_fail++; $display("FAIL midrst_clear got led%b busy%b pend%0d exp 0 0 0", led_out, busy, pending);
        end
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, 1'b0);
            n_tests++;
            if (led_out !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL midrst_quiet cyc %0d got led%b busy%b exp 0 0", i, led_out, busy);
            end
        end
    endtask

    task automatic test_random();
        bit ev;
        bit rst;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if (i < 300) ev = ($urandom_range(3) == 0);
            else ev = ($urandom_range(11) == 0);
            if (i > 200 && i < 260) ev = 1'b1;
            rst = ($urandom_range(149) == 0);
            tick(ev, rst);
            n_tests++;
            if ({led_out, busy, pending, overflow} !== {exp_led(), exp_busy(), PEND_W'(m_pend), m_ovf}) begin
                n_fail++;
                $display("FAIL rand cyc %0d got led%b busy%b pend%0d ovf%b exp led%b busy%b pend%0d ovf%b",
                         i, led_out, busy, pending, overflow, exp_led(), exp_busy(), m_pend, m_ovf);
            end
        end
    endtask

`ifdef EVENT_EDGE_EN
    task automatic test_edge();
        int  rises;
        int  first;
        logic prev;
        rises = 0;
        first = -1;
        prev  = 1'b0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick(i < 20, 1'b0);
            if (led_out === 1'b1 && prev === 1'b0) begin
                rises++;
                if (first < 0) first = i;
            end
            prev = led_out;
            n_tests++;
            if (pending !== '0 || overflow !== 1'b0 || led_out !== exp_led()) begin
                n_fail++; $display("FAIL edge cyc %0d got led%b pend%0d ovf%b exp led%b pend0 ovf0",
                                   i, led_out, pending, overflow, exp_led());
            end
        end
        n_tests++;
        if (rises != 1) begin
            n_fail++; $display("FAIL edge_blinks got %0d exp 1", rises);
        end
        n_tests++;
        if (first != 1) begin
            n_fail++; $display("FAIL edge_latency got %0d exp 1", first);
        end
    endtask
`endif

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_edge    = 0;
        m_start   = 0;
        m_started = 1'b0;
        m_pend    = 0;
        m_ovf     = 1'b0;
        m_in1     = 1'b0;
        m_strb    = 1'b0;
        event_in  = 1'b0;
        reset     = 1'b1;

        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_last_off();
        test_reset_mid();
`ifdef EVENT_EDGE_EN
        test_edge();
`endif
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
